// File: rtl/spi_minion_arbiter.sv
// spi_minion_arbiter: round-robin share of one downstream request channel among three SPI minions, with an in-order ID queue routing responses back.
// Optional per-minion saturating grant counters under SPI_ARB_GRANT_CNT_EN.
module spi_minion_arbiter #(
  parameter int NBITS = 32,
  parameter int IDQ_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       req_val,
  output logic [2:0]       req_rdy,
  input  logic [3*NBITS-1:0] req_msg,
  output logic             dn_req_val,
  input  logic             dn_req_rdy,
  output logic [NBITS-1:0] dn_req_msg,
  input  logic             dn_resp_val,
  output logic             dn_resp_rdy,
  input  logic [NBITS-1:0] dn_resp_msg,
  output logic [2:0]       resp_val,
  input  logic [2:0]       resp_rdy,
  output logic [NBITS-1:0] resp_msg,
  output logic             busy,
  output logic             err
`ifdef SPI_ARB_GRANT_CNT_EN
  ,
  output logic [47:0]      grant_cnt
`endif
);
  localparam int AW = $clog2(IDQ_DEPTH);
  logic [1:0] ptr_q, ptr_d, win, head, cand;
  logic [2:0] sum;
  logic [1:0] idq_q [IDQ_DEPTH];
  logic [1:0] idq_d [IDQ_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic err_q, err_d, full, empty, push, pop;
  // Later search offsets overwrite earlier ones, so iterate from farthest to nearest.
  always_comb begin
    win = ptr_q;
    sum = '0;
    cand = '0;
    for (int k = 2; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + 3'(k);
      cand = sum >= 3'd3 ? 2'(sum - 3'd3) : sum[1:0];
      if (req_val[cand]) win = cand;
    end
  end
  assign full = cnt_q == (AW+1)'(IDQ_DEPTH);
  assign empty = cnt_q == '0;
  assign head = idq_q[rd_q];
  assign dn_req_val = |req_val & !full & !reset;
  assign req_rdy = (dn_req_val & dn_req_rdy) ? 3'b001 << win : 3'b000;
  assign dn_req_msg = |req_val ? req_msg[win*NBITS +: NBITS] : '0;
  assign dn_resp_rdy = !empty & !reset & resp_rdy[head];
  assign resp_val = (dn_resp_val & !empty & !reset) ? 3'b001 << head : 3'b000;
  assign resp_msg = dn_resp_msg;
  assign busy = !empty;
  assign err = err_q;
  assign push = dn_req_val & dn_req_rdy;
  assign pop = dn_resp_val & dn_resp_rdy;
  always_comb begin
    idq_d = idq_q;
    if (push) idq_d[wr_q] = win;
    ptr_d = push ? (win == 2'd2 ? 2'd0 : win + 2'd1) : ptr_q;
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    err_d = err_q | (dn_resp_val & empty);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  // Entries are only read while counted valid, so they need no reset.
  always_ff @(posedge clk) idq_q <= idq_d;
`ifdef SPI_ARB_GRANT_CNT_EN
  logic [15:0] gc_q [3];
  logic [15:0] gc_d [3];
  always_comb begin
    for (int k = 0; k < 3; k++)
      gc_d[k] = (push && win == 2'(k) && gc_q[k] != 16'hFFFF) ? gc_q[k] + 16'd1 : gc_q[k];
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) gc_q[k] <= reset ? 16'd0 : gc_d[k];
  end
  assign grant_cnt = {gc_q[2], gc_q[1], gc_q[0]};
`else
`endif
endmodule

// File: tb/tb_spi_minion_arbiter.sv
// tb_spi_minion_arbiter: directed vector table plus hand sequences for the minion arbiter.
module tb_spi_minion_arbiter;
  logic clk = 1'b0, reset;
  logic [2:0] req_val, req_rdy, resp_val, resp_rdy;
  logic [95:0] req_msg;
  logic dn_req_val, dn_req_rdy, dn_resp_val, dn_resp_rdy, busy, err;
  logic [31:0] dn_req_msg, dn_resp_msg, resp_msg;
`ifdef SPI_ARB_GRANT_CNT_EN
  logic [47:0] grant_cnt;
`endif
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  spi_minion_arbiter #(.NBITS(32), .IDQ_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
    .dn_req_val(dn_req_val), .dn_req_rdy(dn_req_rdy), .dn_req_msg(dn_req_msg),
    .dn_resp_val(dn_resp_val), .dn_resp_rdy(dn_resp_rdy), .dn_resp_msg(dn_resp_msg),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg), .busy(busy), .err(err)
`ifdef SPI_ARB_GRANT_CNT_EN
    , .grant_cnt(grant_cnt)
`endif
  );
  typedef struct {
    logic [2:0] rv; logic rdy; logic rsv; logic [2:0] rr;
    logic e_val; logic [2:0] e_rrdy; logic [31:0] e_msg; logic [2:0] e_rv; logic e_drr; logic e_busy; logic e_err;
  } vec_t;
  vec_t v [14];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [2:0] rv, input logic rdy, input logic rsv, input logic [2:0] rr);
    req_val = rv; dn_req_rdy = rdy; dn_resp_val = rsv; resp_rdy = rr;
    #2;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    drive(3'b000, 1'b0, 1'b0, 3'b000);
    cyc(); cyc();
    reset = 1'b0;
  endtask
  initial begin
    req_msg = {32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
    dn_resp_msg = 32'h0;
    //      rv      rdy   rsv   rr       val   rrdy    msg            rv      drr   busy  err
    v[0]  = '{3'b111, 1'b1, 1'b0, 3'b000, 1'b1, 3'b001, 32'hCAFE0000, 3'b000, 1'b0, 1'b0, 1'b0};
    v[1]  = '{3'b111, 1'b1, 1'b0, 3'b000, 1'b1, 3'b010, 32'hCAFE0001, 3'b000, 1'b0, 1'b1, 1'b0};
    v[2]  = '{3'b111, 1'b1, 1'b0, 3'b000, 1'b1, 3'b100, 32'hCAFE0002, 3'b000, 1'b0, 1'b1, 1'b0};
    v[3]  = '{3'b111, 1'b1, 1'b0, 3'b000, 1'b1, 3'b001, 32'hCAFE0000, 3'b000, 1'b0, 1'b1, 1'b0};
    v[4]  = '{3'b111, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 32'hCAFE0001, 3'b000, 1'b0, 1'b1, 1'b0};
    v[5]  = '{3'b000, 1'b1, 1'b1, 3'b111, 1'b0, 3'b000, 32'h0,        3'b001, 1'b1, 1'b1, 1'b0};
    v[6]  = '{3'b000, 1'b1, 1'b1, 3'b101, 1'b0, 3'b000, 32'h0,        3'b010, 1'b0, 1'b1, 1'b0};
    v[7]  = '{3'b000, 1'b1, 1'b1, 3'b111, 1'b0, 3'b000, 32'h0,        3'b010, 1'b1, 1'b1, 1'b0};
    v[8]  = '{3'b100, 1'b1, 1'b1, 3'b111, 1'b1, 3'b100, 32'hCAFE0002, 3'b100, 1'b1, 1'b1, 1'b0};
    v[9]  = '{3'b000, 1'b1, 1'b1, 3'b111, 1'b0, 3'b000, 32'h0,        3'b001, 1'b1, 1'b1, 1'b0};
    v[10] = '{3'b000, 1'b1, 1'b1, 3'b111, 1'b0, 3'b000, 32'h0,        3'b100, 1'b1, 1'b1, 1'b0};
    v[11] = '{3'b000, 1'b1, 1'b1, 3'b111, 1'b0, 3'b000, 32'h0,        3'b000, 1'b0, 1'b0, 1'b0};
    v[12] = '{3'b010, 1'b0, 1'b0, 3'b111, 1'b1, 3'b000, 32'hCAFE0001, 3'b000, 1'b0, 1'b0, 1'b1};
    v[13] = '{3'b011, 1'b1, 1'b0, 3'b111, 1'b1, 3'b001, 32'hCAFE0000, 3'b000, 1'b0, 1'b0, 1'b1};
    do_reset();
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    for (int i = 0; i < 14; i++) begin
      drive(v[i].rv, v[i].rdy, v[i].rsv, v[i].rr);
      chk($sformatf("v%0d_dn_req_val", i), dn_req_val, v[i].e_val);
      chk($sformatf("v%0d_req_rdy", i), req_rdy, v[i].e_rrdy);
      chk($sformatf("v%0d_dn_req_msg", i), dn_req_msg, v[i].e_msg);
      chk($sformatf("v%0d_resp_val", i), resp_val, v[i].e_rv);
      chk($sformatf("v%0d_dn_resp_rdy", i), dn_resp_rdy, v[i].e_drr);
      chk($sformatf("v%0d_busy", i), busy, v[i].e_busy);
      chk($sformatf("v%0d_err", i), err, v[i].e_err);
      cyc();
    end
    chk("err_sticky", err, 1'b1);
    // Reset dominates live requests and clears the sticky error.
    reset = 1'b1;
    drive(3'b111, 1'b1, 1'b1, 3'b111);
    chk("rst_dn_req_val", dn_req_val, 1'b0);
    chk("rst_req_rdy", req_rdy, 3'b000);
    chk("rst_dn_resp_rdy", dn_resp_rdy, 1'b0);
    cyc();
    reset = 1'b0;
    drive(3'b000, 1'b0, 1'b0, 3'b000);
    chk("rst_err_clr", err, 1'b0);
    chk("rst_busy_clr", busy, 1'b0);
    // Lone minion 2 stalled by downstream, then accepted once.
    for (int i = 0; i < 3; i++) begin
      drive(3'b100, 1'b0, 1'b0, 3'b000);
      chk("stall_msg", dn_req_msg, 32'hCAFE0002);
      chk("stall_val", dn_req_val, 1'b1);
      chk("stall_rdy", req_rdy, 3'b000);
      cyc();
    end
    drive(3'b100, 1'b1, 1'b0, 3'b000);
    chk("m2_rdy", req_rdy, 3'b100);
    chk("m2_msg", dn_req_msg, 32'hCAFE0002);
    cyc();
    drive(3'b111, 1'b0, 1'b0, 3'b000);
    chk("ptr_wrap0", dn_req_msg, 32'hCAFE0000);
    chk("m2_busy", busy, 1'b1);
    do_reset();
    // Fill queue with IDs 1,0,2,1 and check the fifth is blocked.
    begin
      logic [2:0] pat [4];
      pat = '{3'b010, 3'b001, 3'b100, 3'b010};
      for (int i = 0; i < 4; i++) begin
        drive(pat[i], 1'b1, 1'b0, 3'b000);
        chk("fill_rdy", req_rdy, pat[i]);
        cyc();
      end
    end
    drive(3'b111, 1'b1, 1'b0, 3'b000);
    chk("full_blk_val", dn_req_val, 1'b0);
    chk("full_blk_rdy", req_rdy, 3'b000);
    // Pop while full: request must wait one cycle.
    dn_resp_msg = 32'hA0;
    drive(3'b001, 1'b1, 1'b1, 3'b111);
    chk("fullpop_val", dn_req_val, 1'b0);
    chk("fullpop_resp_val", resp_val, 3'b010);
    chk("fullpop_resp_msg", resp_msg, 32'hA0);
    chk("fullpop_drr", dn_resp_rdy, 1'b1);
    cyc();
    drive(3'b001, 1'b1, 1'b0, 3'b111);
    chk("after_pop_val", dn_req_val, 1'b1);
    chk("after_pop_rdy", req_rdy, 3'b001);
    cyc();
    begin
      logic [2:0] ev [4];
      ev = '{3'b001, 3'b100, 3'b010, 3'b001};
      for (int i = 0; i < 4; i++) begin
        dn_resp_msg = 32'hA1 + 32'(i);
        drive(3'b000, 1'b0, 1'b1, 3'b111);
        chk("drain_resp_val", resp_val, ev[i]);
        chk("drain_resp_msg", resp_msg, 32'hA1 + 32'(i));
        chk("drain_busy", busy, 1'b1);
        cyc();
      end
    end
    drive(3'b000, 1'b0, 1'b0, 3'b000);
    chk("drain_empty", busy, 1'b0);
    chk("drain_no_err", err, 1'b0);
`ifdef SPI_ARB_GRANT_CNT_EN
    do_reset();
    drive(3'b001, 1'b1, 1'b1, 3'b111);
    for (int i = 0; i < 70000; i++) cyc();
    chk("gc_sat", grant_cnt, {16'h0, 16'h0, 16'hFFFF});
    reset = 1'b1;
    #2;
    cyc();
    reset = 1'b0;
    drive(3'b000, 1'b0, 1'b0, 3'b000);
    chk("gc_rst", grant_cnt, 48'h0);
    chk("gc_rst_busy", busy, 1'b0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
